alu_byte_sequencer: RTL

//  Multi-byte arithmetic front/back end for the 8-bit combinational ALU.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_byte_sequencer_if.sv | 51 +++++
 rtl/alu_flag_unit.sv | 33 +++
 rtl/alu_byte_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the byte-serial ALU sequencer: opcodes, FSM state
// encoding and the packed flag bundle.
package alu_pkg;

  // ALU opcodes
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SUBA = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_ANDN = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_XNOR = 3'b111;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_t;

  // Result flags carried with a response
  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_byte_sequencer_if.sv
// Bus bundle between the sequencer and its surroundings.
//   req_*  : request port (valid/ready), operands of W = 8*BYTES bits
//   alu_*  : byte-wide link to the external combinational 8-bit ALU
//   rsp_*  : response port (valid/ready), result word and C/Z/N/V flags
// slave  : sequencer side; master : environment side (requester, ALU, consumer).
interface alu_byte_sequencer_if #(
  parameter int unsigned BYTES = 2
);
  localparam int unsigned W = 8 * BYTES;

  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_oper;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;

  logic [2:0]   alu_oper;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic         alu_cin;
  logic [7:0]   alu_sum;
  logic         alu_cout;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_c;
  logic         rsp_z;
  logic         rsp_n;
  logic         rsp_v;

  modport slave (
    input  req_valid, req_oper, req_a, req_b, req_cin,
    output req_ready,
    output alu_oper, alu_a, alu_b, alu_cin,
    input  alu_sum, alu_cout,
    output rsp_valid, rsp_result, rsp_c, rsp_z, rsp_n, rsp_v,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_oper, req_a, req_b, req_cin,
    input  req_ready,
    input  alu_oper, alu_a, alu_b, alu_cin,
    output alu_sum, alu_cout,
    input  rsp_valid, rsp_result, rsp_c, rsp_z, rsp_n, rsp_v,
    output rsp_ready
  );

endinterface

// File: rtl/alu_flag_unit.sv
// Combinational C/Z/N/V for the final byte of a multi-byte operation.
//   oper    : opcode of the operation
//   a7, b7  : sign bits of operands A and B
//   sum     : ALU sum of the top byte (its bit 7 is the result sign)
//   cout    : ALU carry out of the top byte
//   zacc    : 1 when every lower result byte was zero
//   flags_c : resulting flags
module alu_flag_unit
  import alu_pkg::*;
(
  input  logic [2:0] oper,
  input  logic       a7,
  input  logic       b7,
  input  logic [7:0] sum,
  input  logic       cout,
  input  logic       zacc,
  output alu_flags_t flags_c
);

  // Overflow only has meaning for the signed add/subtract opcodes
  always_comb begin
    flags_c   = '0;
    flags_c.c = cout;
    flags_c.z = zacc & (sum == 8'h00);
    flags_c.n = sum[7];
    case (oper)
      ALU_ADD: flags_c.v = (a7 == b7) && (sum[7] != a7);
      ALU_SUB: flags_c.v = (a7 != b7) && (sum[7] != a7);
      default: flags_c.v = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_byte_sequencer.sv
// Multi-byte front/back end for an external 8-bit combinational ALU.
// Accepts one BYTES-wide operation, feeds the ALU one byte per cycle LSB
// first with carry chained between bytes, and returns the full result with
// C/Z/N/V flags.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_byte_sequencer_if.slave (req_*, alu_*, rsp_*)
module alu_byte_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned BYTES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_byte_sequencer_if.slave bus
);

  localparam int unsigned W     = 8 * BYTES;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned LAST  = BYTES - 1;

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [2:0]       oper_q;
  logic [W-1:0]     a_sh_q, b_sh_q;
  logic [W-1:0]     res_q;
  logic             a7_q, b7_q;
  logic             zacc_q;

  logic             req_ready_q;
  logic [2:0]       alu_oper_q;
  logic [7:0]       alu_a_q, alu_b_q;
  logic             alu_cin_q;
  logic             rsp_valid_q;
  logic [W-1:0]     rsp_result_q;
  alu_flags_t       rsp_flags_q;

  logic             accept_c, last_c, retire_c;
  logic [W-1:0]     res_next_c;
  alu_flags_t       flags_c;

  assign accept_c = (state_q == IDLE) && bus.req_valid && req_ready_q;
  assign last_c   = (state_q == RUN) && (idx_q == IDX_W'(LAST));
  assign retire_c = (state_q == DONE) && bus.rsp_ready;

  // Result bytes enter at the top and shift down, so after BYTES steps
  // byte 0 sits at the bottom.
  assign res_next_c = (res_q >> 8) | (W'(bus.alu_sum) << (W - 8));

  alu_flag_unit u_flags (
    .oper    (oper_q),
    .a7      (a7_q),
    .b7      (b7_q),
    .sum     (bus.alu_sum),
    .cout    (bus.alu_cout),
    .zacc    (zacc_q),
    .flags_c (flags_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = RUN;
      RUN:     if (last_c)   state_d = DONE;
      DONE:    if (retire_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs. The alu_* registers always present the
  // byte for the cycle now in progress, so the next byte is loaded one edge
  // early; alu_cin doubles as the chained carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      oper_q       <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      a7_q         <= 1'b0;
      b7_q         <= 1'b0;
      zacc_q       <= 1'b1;
      req_ready_q  <= 1'b1;
      alu_oper_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            oper_q      <= bus.req_oper;
            a_sh_q      <= bus.req_a;
            b_sh_q      <= bus.req_b;
            a7_q        <= bus.req_a[W-1];
            b7_q        <= bus.req_b[W-1];
            idx_q       <= '0;
            zacc_q      <= 1'b1;
            req_ready_q <= 1'b0;
            alu_oper_q  <= bus.req_oper;
            alu_a_q     <= bus.req_a[7:0];
            alu_b_q     <= bus.req_b[7:0];
            alu_cin_q   <= bus.req_cin;
          end
        end
        RUN: begin
          res_q  <= res_next_c;
          zacc_q <= zacc_q & (bus.alu_sum == 8'h00);
          a_sh_q <= a_sh_q >> 8;
          b_sh_q <= b_sh_q >> 8;
          if (last_c) begin
            // Park the ALU inputs and publish the response
            alu_oper_q   <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= res_next_c;
            rsp_flags_q  <= flags_c;
          end else begin
            idx_q     <= idx_q + IDX_W'(1);
            alu_a_q   <= 8'(a_sh_q >> 8);
            alu_b_q   <= 8'(b_sh_q >> 8);
            alu_cin_q <= bus.alu_cout;
          end
        end
        DONE: begin
          if (retire_c) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.alu_oper   = alu_oper_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_cin    = alu_cin_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_c      = rsp_flags_q.c;
  assign bus.rsp_z      = rsp_flags_q.z;
  assign bus.rsp_n      = rsp_flags_q.n;
  assign bus.rsp_v      = rsp_flags_q.v;

endmodule
